// File: rtl/controle_acesso_pkg.sv
// Shared types and constants for the access sequencer.
// Holds the keypad PIN bundles and lockout helpers.
package controle_acesso_pkg;

    typedef struct packed {
        logic [3:0][3:0] digitos;
        logic            status;
    } pinPac_t;

    typedef struct packed {
        logic [3:0][3:0] digitos;
        logic            master;
        logic            status;
    } setupPac_t;

    localparam int         LOCK_LEVEL_MAX = 2;
    localparam logic [3:0] PIN_VAZIO      = 4'hF;

    function automatic logic [1:0] nivel_next(input logic [1:0] n);
        if (n >= 2'(LOCK_LEVEL_MAX))
            return 2'(LOCK_LEVEL_MAX);
        return n + 2'd1;
    endfunction

endpackage

// File: rtl/controle_acesso_temporizador.sv
// Loadable down-counter shared by the response, open and lockout timers.
// Load wins over enable; the count holds at zero.
module temporizador_regressivo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_en && (r_count != '0))
            r_count <= r_count - W'(1);
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/controle_acesso.sv
// Access sequencer: forwards one PIN per attempt, waits for the verdict,
// then opens the door, enters setup or imposes an escalating lockout.
module controle_acesso
    import controle_acesso_pkg::*;
#(
    parameter int MAX_FAIL     = 3,
    parameter int OPEN_CYCLES  = 250_000_000,
    parameter int LOCK_CYCLES  = 500_000_000,
    parameter int RESP_TIMEOUT = 64,
    parameter int TIMER_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  pinPac_t            pin_in,
    input  logic               senha_fail,
    input  logic               senha_padrao,
    input  logic               senha_master,
    input  logic               setup_done,
    output pinPac_t            pin_out,
    output logic               tranca_aberta,
    output logic               modo_setup,
    output logic               bloqueado,
    output logic [1:0]         tentativas,
    output logic [TIMER_W-1:0] tempo_restante,
    output logic               erro_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        ENVIA,
        AGUARDA,
        ABERTO,
        SETUP,
        BLOQUEIO
    } estado_t;

    estado_t r_estado;
    estado_t w_next;

    logic            r_status_d;
    logic [3:0][3:0] r_digitos;
    logic            r_envia;
    logic            r_aberta;
    logic            r_setup;
    logic            r_bloq;
    logic            r_timeout;
    logic [1:0]      r_fails;
    logic [1:0]      r_nivel;

    logic               w_new_pin;
    logic               w_ld;
    logic [TIMER_W-1:0] w_ld_val;
    logic               w_en;
    logic [TIMER_W-1:0] w_count;
    logic               w_zero;
    logic [TIMER_W-1:0] w_lock_val;
    logic [2:0]         w_fails_inc;
    logic               w_captura;
    logic               w_limpa;
    logic               w_falha;
    logic               w_timeout;
    logic               w_bloqueia;
    logic               w_libera;

    assign w_new_pin   = pin_in.status & ~r_status_d;
    assign w_lock_val  = TIMER_W'(LOCK_CYCLES) << r_nivel;
    assign w_fails_inc = {1'b0, r_fails} + 3'd1;

    temporizador_regressivo #(
        .W(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_ld),
        .i_load_val(w_ld_val),
        .i_en      (w_en),
        .o_count   (w_count),
        .o_zero    (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_estado <= IDLE;
        else
            r_estado <= w_next;
    end

    always_comb begin
        w_next     = r_estado;
        w_ld       = 1'b0;
        w_ld_val   = '0;
        w_en       = 1'b0;
        w_captura  = 1'b0;
        w_limpa    = 1'b0;
        w_falha    = 1'b0;
        w_timeout  = 1'b0;
        w_bloqueia = 1'b0;
        w_libera   = 1'b0;
        unique case (r_estado)
            IDLE: begin
                if (w_new_pin) begin
                    w_next    = ENVIA;
                    w_captura = 1'b1;
                end
            end
            ENVIA: begin
                w_ld     = 1'b1;
                w_ld_val = TIMER_W'(RESP_TIMEOUT);
                w_next   = AGUARDA;
            end
            AGUARDA: begin
                w_en = 1'b1;
                if (senha_master) begin
                    w_next  = SETUP;
                    w_limpa = 1'b1;
                end else if (senha_padrao) begin
                    w_next   = ABERTO;
                    w_limpa  = 1'b1;
                    w_ld     = 1'b1;
                    w_ld_val = TIMER_W'(OPEN_CYCLES);
                end else if (senha_fail || w_zero) begin
                    // an explicit fail in the last cycle is not a timeout
                    w_falha   = 1'b1;
                    w_timeout = ~senha_fail;
                    if (w_fails_inc == 3'(MAX_FAIL)) begin
                        w_next     = BLOQUEIO;
                        w_bloqueia = 1'b1;
                        w_ld       = 1'b1;
                        w_ld_val   = w_lock_val;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            ABERTO: begin
                w_en = 1'b1;
                if (w_count <= TIMER_W'(1))
                    w_next = IDLE;
            end
            SETUP: begin
                if (setup_done)
                    w_next = IDLE;
            end
            BLOQUEIO: begin
                w_en = 1'b1;
                if (w_count <= TIMER_W'(1)) begin
                    w_next   = IDLE;
                    w_libera = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status_d <= 1'b0;
            r_digitos  <= {4{PIN_VAZIO}};
            r_envia    <= 1'b0;
            r_aberta   <= 1'b0;
            r_setup    <= 1'b0;
            r_bloq     <= 1'b0;
            r_timeout  <= 1'b0;
            r_fails    <= 2'd0;
            r_nivel    <= 2'd0;
        end else begin
            r_status_d <= pin_in.status;
            if (w_captura)
                r_digitos <= pin_in.digitos;
            r_envia   <= (w_next == ENVIA);
            r_aberta  <= (w_next == ABERTO);
            r_setup   <= (w_next == SETUP);
            r_bloq    <= (w_next == BLOQUEIO);
            r_timeout <= w_timeout;
            if (w_limpa) begin
                r_fails <= 2'd0;
                r_nivel <= 2'd0;
            end else if (w_bloqueia) begin
                r_fails <= 2'(MAX_FAIL);
                r_nivel <= nivel_next(r_nivel);
            end else if (w_falha) begin
                r_fails <= w_fails_inc[1:0];
            end else if (w_libera) begin
                r_fails <= 2'd0;
            end
        end
    end

    assign pin_out.digitos = r_digitos;
    assign pin_out.status  = r_envia;
    assign tranca_aberta   = r_aberta;
    assign modo_setup      = r_setup;
    assign bloqueado       = r_bloq;
    assign tentativas      = r_fails;
    assign erro_timeout    = r_timeout;
    assign tempo_restante  = (r_aberta || r_bloq) ? w_count : '0;

endmodule

// File: tb/tb_controle_acesso.sv
// Randomized bench for controle_acesso against an attempt-level model.
// Model tracks failures and lock level; timings follow from the rules.
module tb_controle_acesso;
    import controle_acesso_pkg::*;

    localparam int MF  = 3;
    localparam int OPN = 10;
    localparam int LCK = 20;
    localparam int RSP = 8;

    localparam int K_TMO  = 0;
    localparam int K_FAIL = 1;
    localparam int K_OK   = 2;
    localparam int K_MST  = 3;
    localparam int K_MSTF = 4;

    logic        clk = 1'b0;
    logic        rst;
    pinPac_t     pin_in;
    pinPac_t     pin_out;
    logic        senha_fail;
    logic        senha_padrao;
    logic        senha_master;
    logic        setup_done;
    logic        tranca_aberta;
    logic        modo_setup;
    logic        bloqueado;
    logic [1:0]  tentativas;
    logic [31:0] tempo_restante;
    logic        erro_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int m_fails = 0;
    int m_nivel = 0;

    always #5 clk = ~clk;

    controle_acesso #(
        .MAX_FAIL    (MF),
        .OPEN_CYCLES (OPN),
        .LOCK_CYCLES (LCK),
        .RESP_TIMEOUT(RSP),
        .TIMER_W     (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pin_in        (pin_in),
        .senha_fail    (senha_fail),
        .senha_padrao  (senha_padrao),
        .senha_master  (senha_master),
        .setup_done    (setup_done),
        .pin_out       (pin_out),
        .tranca_aberta (tranca_aberta),
        .modo_setup    (modo_setup),
        .bloqueado     (bloqueado),
        .tentativas    (tentativas),
        .tempo_restante(tempo_restante),
        .erro_timeout  (erro_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic busy();
        return tranca_aberta | modo_setup | bloqueado |
               erro_timeout | pin_out.status;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_outs"}, 32'({tranca_aberta, modo_setup, bloqueado,
            erro_timeout, pin_out.status, tentativas}), 32'd0);
        chk({tag, "_tempo"}, tempo_restante, 32'd0);
        chk({tag, "_dig"}, 32'(pin_out.digitos), 32'hFFFF);
    endtask

    task automatic tentativa(input int kind, input bit rst_mid,
                             input logic [15:0] pin, input int dly);
        int   d;
        int   lat;
        int   len;
        int   dur;
        int   n;
        bit   stray;
        bit   hold;
        pin_in.status = 1'b0;
        tick();
        pin_in.digitos = pin;
        pin_in.status  = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!pin_out.status && lat < 5);
        chk("send_lat", 32'(lat), 32'd1);
        chk("pin_dig", 32'(pin_out.digitos), 32'(pin));
        tick();
        chk("send_1cyc", 32'(pin_out.status), 32'd0);
        if (kind == K_TMO)
            d = RSP + 1;
        else if (dly > 0)
            d = dly;
        else
            d = int'($urandom_range(RSP + 1, 1));
        stray = 1'b0;
        for (int k = 1; k < d; k++) begin
            stray |= busy();
            tick();
        end
        stray |= busy();
        chk("quiet_wait", 32'(stray), 32'd0);
        hold = 1'b0;
        unique case (kind)
            K_FAIL: senha_fail = 1'b1;
            K_OK: begin
                senha_padrao = 1'b1;
                hold = 1'($urandom_range(1, 0));
            end
            K_MST: senha_master = 1'b1;
            K_MSTF: begin
                senha_master = 1'b1;
                senha_fail   = 1'b1;
            end
            default: ;
        endcase
        tick();
        senha_fail   = 1'b0;
        senha_master = 1'b0;
        if (!hold)
            senha_padrao = 1'b0;
        chk("erro_pulse", 32'(erro_timeout), 32'(kind == K_TMO));
        if (kind == K_MST || kind == K_MSTF) begin
            m_fails = 0;
            m_nivel = 0;
            chk("setup_on", 32'(modo_setup), 32'd1);
            chk("tent_setup", 32'(tentativas), 32'd0);
            n = int'($urandom_range(4, 0));
            repeat (n) tick();
            chk("setup_hold", 32'(modo_setup), 32'd1);
            setup_done = 1'b1;
            tick();
            setup_done = 1'b0;
            chk("setup_off", 32'(modo_setup), 32'd0);
        end else if (kind == K_OK) begin
            m_fails = 0;
            m_nivel = 0;
            chk("door_on", 32'(tranca_aberta), 32'd1);
            chk("tent_ok", 32'(tentativas), 32'd0);
            chk("tempo_open", tempo_restante, 32'(OPN));
            if (rst_mid) begin
                repeat (OPN - 5) tick();
                chk("tempo_5", tempo_restante, 32'd5);
                rst           = 1'b1;
                pin_in.status = 1'b0;
                senha_padrao  = 1'b0;
                tick();
                chk("rst_door", 32'(tranca_aberta), 32'd0);
                chk_zero("rst_mid");
                rst = 1'b0;
            end else begin
                len = 0;
                while (tranca_aberta && len < OPN + 5) begin
                    len++;
                    tick();
                end
                senha_padrao = 1'b0;
                chk("door_len", 32'(len), 32'(OPN));
            end
        end else begin
            m_fails++;
            if (m_fails == MF) begin
                dur = LCK << m_nivel;
                m_nivel = (m_nivel < 2) ? m_nivel + 1 : 2;
                chk("lock_on", 32'(bloqueado), 32'd1);
                chk("tent_sat", 32'(tentativas), 32'(MF));
                chk("tempo_lock", tempo_restante, 32'(dur));
                len = 0;
                stray = 1'b0;
                while (bloqueado && len < dur + 5) begin
                    len++;
                    stray |= pin_out.status;
                    pin_in.status = 1'($urandom_range(1, 0));
                    tick();
                end
                pin_in.status = 1'b0;
                m_fails = 0;
                chk("lock_len", 32'(len), 32'(dur));
                chk("lock_drop", 32'(stray), 32'd0);
                chk("tent_clr", 32'(tentativas), 32'd0);
            end else begin
                chk("tent_inc", 32'(tentativas), 32'(m_fails));
                chk("no_lock", 32'(bloqueado), 32'd0);
                chk("tempo_idle", tempo_restante, 32'd0);
            end
        end
        if (kind == K_TMO) begin
            tick();
            chk("erro_1cyc", 32'(erro_timeout), 32'd0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, got hang expected finish");
        $fatal(1);
    end

    initial begin
        int r;
        int pulses;
        int erros;
        rst          = 1'b1;
        pin_in       = '0;
        senha_fail   = 1'b0;
        senha_padrao = 1'b0;
        senha_master = 1'b0;
        setup_done   = 1'b0;
        repeat (2) tick();
        chk_zero("reset");
        rst = 1'b0;

        pin_in.digitos = 16'h1234;
        tick();
        pin_in.status = 1'b1;
        pulses = 0;
        erros  = 0;
        repeat (50) begin
            tick();
            pulses += int'(pin_out.status);
            erros  += int'(erro_timeout);
        end
        pin_in.status = 1'b0;
        m_fails = 1;
        chk("held_one", 32'(pulses), 32'd1);
        chk("held_tmo", 32'(erros), 32'd1);
        chk("held_tent", 32'(tentativas), 32'd1);

        tentativa(K_OK, 1'b0, 16'h1234, 2);
        tentativa(K_TMO, 1'b0, 16'h0042, 0);
        tentativa(K_MSTF, 1'b0, 16'h9999, 0);
        repeat (18) tentativa(K_FAIL, 1'b0, 16'($urandom), 0);
        tentativa(K_OK, 1'b1, 16'h5555, 0);

        repeat (60) begin
            r = int'($urandom_range(9, 0));
            if (r < 2)
                tentativa(K_TMO, 1'b0, 16'($urandom), 0);
            else if (r < 6)
                tentativa(K_FAIL, 1'b0, 16'($urandom), 0);
            else if (r < 8)
                tentativa(K_OK, 1'b0, 16'($urandom), 0);
            else if (r < 9)
                tentativa(K_MST, 1'b0, 16'($urandom), 0);
            else
                tentativa(K_MSTF, 1'b0, 16'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
